// File: rtl/div16_seq.sv
// div16_seq: sequential radix-2 restoring divider, one quotient bit per cycle.
// Optional signed mode is compiled in only when DIV16_SIGNED_EN is defined.
// Without the macro the signed_op port and all sign-correction logic vanish.
//
// state | meaning
// IDLE  | waiting for operands, start_ready=1
// RUN   | WIDTH iterations of shift / trial subtract
// DONE  | result presented with out_valid=1 until consumed

module div16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV16_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dvd_raw;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_part;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    start_ready = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = start_valid && start_ready;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Restoring step: the partial remainder is always below the divisor, so the
  // WIDTH+1-bit difference fits and its top bit is the borrow.
  assign w_part    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_part - {1'b0, r_dvs};
  assign w_borrow  = w_trial[WIDTH];
  assign w_rem_nxt = w_borrow ? w_part[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};

`ifdef DIV16_SIGNED_EN
  logic w_dvd_neg;
  logic w_dvs_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_dvd_neg = signed_op && dividend[WIDTH-1];
  assign w_dvs_neg = signed_op && divisor[WIDTH-1];
  // Magnitudes; the most negative value maps onto itself, which is exactly
  // its unsigned magnitude.
  assign w_dvd_mag = w_dvd_neg ? ({WIDTH{1'b0}} - dividend) : dividend;
  assign w_dvs_mag = w_dvs_neg ? ({WIDTH{1'b0}} - divisor)  : divisor;
  assign w_q_res   = r_neg_q ? ({WIDTH{1'b0}} - w_quo_nxt) : w_quo_nxt;
  assign w_r_res   = r_neg_r ? ({WIDTH{1'b0}} - w_rem_nxt) : w_rem_nxt;

  // Result signs latched with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_q_res   = w_quo_nxt;
  assign w_r_res   = w_rem_nxt;
`endif

  // Operand capture, iteration, and result registers (loaded on the last step).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_dvd_raw     <= '0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= w_dvd_mag;
      r_dvs     <= w_dvs_mag;
      r_dvd_raw <= dividend;
      r_dz      <= (divisor == '0);
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      if (w_last) begin
        // Divide by zero overrides the iterated value; latency is unchanged.
        r_quotient    <= r_dz ? {WIDTH{1'b1}} : w_q_res;
        r_remainder   <= r_dz ? r_dvd_raw     : w_r_res;
        r_div_by_zero <= r_dz;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
